muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS-style datapath. It sits directly downstream of the register file and takes its two operands from the register file's ReadData1/ReadData2. It computes MULT, MULTU, DIV or DIVU over multiple cycles and holds the 64-bit result in internal HI/LO registers until the next operation completes. Results are returned to the datapath through the Hi/Lo outputs, which the register-file write path consumes (mfhi/mflo).

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative 32-bit multiply/divide unit (MULTU, MULT, DIVU, DIV).
// One result bit is produced per cycle over 32 RUN cycles. A final FIX cycle
// applies the sign correction and writes the HI/LO result registers.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   Start      request, sampled only while idle
//   Op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   OperandA   multiplicand / dividend (register file ReadData1)
//   OperandB   multiplier / divisor    (register file ReadData2)
//   Busy       operation in progress
//   Done       one-cycle pulse, Hi/Lo valid from this cycle
//   DivByZero  divide with OperandB = 0 (valid with Done, held until next op)
//   Hi         product upper word / remainder
//   Lo         product lower word / quotient
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | 32 iterations, count 31 down to 0
// FIX   | sign correction, Hi/Lo write, Done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, nextState;

    logic [CW-1:0]      count;
    // Multiply: {partial product high, multiplier being shifted out}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic               opDiv;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               negRes;
    logic               negRem;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               dbzReg;
    logic               doneReg;

    logic               accept;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divGe;
    logic [WIDTH-1:0]   divDiff;

    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               isDbz;

    // Only odd opcodes (MULT, DIV) are signed.
    assign signA  = Op[0] & OperandA[WIDTH-1];
    assign signB  = Op[0] & OperandB[WIDTH-1];
    assign absA   = signA ? -OperandA : OperandA;
    assign absB   = signB ? -OperandB : OperandB;
    assign accept = (state == IDLE) && Start;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right, carry included.
    assign addend = acc[0] ? magA : '0;
    assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the difference only when it does not go negative. The compare needs the
    // 33rd bit; the difference itself always fits in WIDTH bits when taken.
    assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign divGe    = divShift >= {1'b0, magB};
    assign divDiff  = divShift[WIDTH-1:0] - magB;

    assign quo   = acc[WIDTH-1:0];
    assign rem   = acc[2*WIDTH-1:WIDTH];
    assign isDbz = (magB == '0);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (count == '0) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            acc     <= '0;
            opDiv   <= 1'b0;
            magA    <= '0;
            magB    <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            dbzReg  <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= (state == FIX);
            if (accept) begin
                count  <= CW'(WIDTH - 1);
                opDiv  <= Op[1];
                magA   <= absA;
                magB   <= absB;
                negRes <= signA ^ signB;
                negRem <= signA;
                acc    <= Op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
            end else if (state == RUN) begin
                count <= count - 1'b1;
                if (opDiv) begin
                    acc <= {(divGe ? divDiff : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divGe};
                end else begin
                    acc <= {mulSum, acc[WIDTH-1:1]};
                end
            end else if (state == FIX) begin
                if (!opDiv) begin
                    {hiReg, loReg} <= negRes ? -acc : acc;
                    dbzReg         <= 1'b0;
                end else if (isDbz) begin
                    // Return the dividend as latched; negRem carries its sign.
                    hiReg  <= negRem ? -magA : magA;
                    loReg  <= '1;
                    dbzReg <= 1'b1;
                end else begin
                    loReg  <= negRes ? -quo : quo;
                    hiReg  <= negRem ? -rem : rem;
                    dbzReg <= 1'b0;
                end
            end
        end
    end

    assign Busy      = (state != IDLE);
    assign Done      = doneReg;
    assign DivByZero = dbzReg;
    assign Hi        = hiReg;
    assign Lo        = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
        .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, C-style truncating signed division.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
            2'b01: begin p = sa * sb; {hi, lo} = p; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; dbz = 1'b1; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; dbz = 1'b1; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
        endcase
    endfunction

    // Issues one operation, scrambles the inputs right after acceptance and
    // waits (bounded) for Done. Returns at #1 after the edge that raised Done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output int busyCnt, output bit timedOut);
        @(negedge clk);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge clk); #1;
        cycles   = 1;
        busyCnt  = Busy ? 1 : 0;
        timedOut = 1'b1;
        Start    = 1'b0;
        Op       = 2'($urandom);
        OperandA = $urandom;
        OperandB = $urandom;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (Done) begin timedOut = 1'b0; break; end
            if (Busy) busyCnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (Hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=0", Hi); end
        tests++; if (Lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=0", Lo); end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", Done); end
        tests++; if (DivByZero !== 1'b0) begin fails++; $display("FAIL reset_dbz got=%b exp=0", DivByZero); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_latency();
        int cyc, bc; bit to;
        run_op(2'b00, 32'd6, 32'd7, cyc, bc, to);
        tests++; if (to) begin fails++; $display("FAIL latency_timeout got=no_done exp=done"); end
        tests++; if (cyc != 34) begin fails++; $display("FAIL latency_cycles got=%0d exp=34", cyc); end
        tests++; if (bc != 33) begin fails++; $display("FAIL latency_busy_cycles got=%0d exp=33", bc); end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got=%b exp=0", Busy); end
        tests++; if (Hi !== 32'd0 || Lo !== 32'd42) begin fails++; $display("FAIL multu_6x7 got=%h_%h exp=0_2a", Hi, Lo); end
        @(posedge clk); #1;
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL done_pulse got=%b exp=0", Done); end
        tests++; if (Lo !== 32'd42) begin fails++; $display("FAIL lo_hold got=%h exp=2a", Lo); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7};
        logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] eh  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1};
        logic [31:0] el  [6] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFD};
        int cyc, bc; bit to;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], cyc, bc, to);
            tests++;
            if (to || Hi !== eh[i] || Lo !== el[i] || DivByZero !== 1'b0) begin
                fails++;
                $display("FAIL directed_%0d got=%h_%h dbz=%b to=%b exp=%h_%h dbz=0", i, Hi, Lo, DivByZero, to, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc, bc; bit to;
        run_op(2'b10, 32'd100, 32'd0, cyc, bc, to);
        tests++; if (to || cyc != 34) begin fails++; $display("FAIL dbz_latency got=%0d exp=34", cyc); end
        tests++; if (Hi !== 32'd100 || Lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL dbz_result got=%h_%h exp=64_ffffffff", Hi, Lo); end
        tests++; if (DivByZero !== 1'b1) begin fails++; $display("FAIL dbz_flag got=%b exp=1", DivByZero); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (DivByZero !== 1'b1) begin fails++; $display("FAIL dbz_hold got=%b exp=1", DivByZero); end
        run_op(2'b00, 32'd2, 32'd2, cyc, bc, to);
        tests++; if (to || DivByZero !== 1'b0 || Lo !== 32'd4 || Hi !== 32'd0) begin
            fails++; $display("FAIL dbz_clear got=%h_%h dbz=%b exp=0_4 dbz=0", Hi, Lo, DivByZero);
        end
    endtask

    task automatic test_start_ignored();
        int doneCnt = 0;
        logic [31:0] hiAt = '0, loAt = '0;
        @(negedge clk);
        Start = 1'b1; Op = 2'b10; OperandA = 32'd50; OperandB = 32'd5;
        @(posedge clk); #1; Start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        Start = 1'b1; Op = 2'b10; OperandA = 32'd9; OperandB = 32'd3;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (i == 6) Start = 1'b0;
            if (Done) begin doneCnt++; hiAt = Hi; loAt = Lo; end
        end
        tests++; if (doneCnt != 1) begin fails++; $display("FAIL ignored_done_count got=%0d exp=1", doneCnt); end
        tests++; if (hiAt !== 32'd0 || loAt !== 32'd10) begin fails++; $display("FAIL ignored_result got=%h_%h exp=0_a", hiAt, loAt); end
    endtask

    task automatic test_reset_mid();
        int doneCnt = 0;
        int cyc, bc; bit to;
        @(negedge clk);
        Start = 1'b1; Op = 2'b00; OperandA = 32'd6; OperandB = 32'd7;
        @(posedge clk); #1; Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1; Start = 1'b1;
        @(posedge clk); #1;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
        tests++; if (Hi !== 32'd0 || Lo !== 32'd0) begin fails++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", Hi, Lo); end
        @(negedge clk); rst = 1'b0; Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Done) doneCnt++;
        end
        tests++; if (doneCnt != 0) begin fails++; $display("FAIL rstmid_no_done got=%0d exp=0", doneCnt); end
        run_op(2'b00, 32'd3, 32'd3, cyc, bc, to);
        tests++; if (to || Hi !== 32'd0 || Lo !== 32'd9) begin fails++; $display("FAIL rstmid_after got=%h_%h exp=0_9", Hi, Lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, eh, el, prevHi, prevLo;
        logic        ed;
        int cyc, bc; bit to;
        bit stable = 1'b1, gotDone = 1'b0;
        int n = 1;
        a = $urandom; b = $urandom;
        run_op(2'b01, a, b, cyc, bc, to);
        model(2'b01, a, b, eh, el, ed);
        tests++; if (to || Hi !== eh || Lo !== el) begin fails++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", Hi, Lo, eh, el); end
        prevHi = Hi; prevLo = Lo;
        a = $urandom; b = 32'($urandom_range(1, 1000));
        model(2'b11, a, b, eh, el, ed);
        @(negedge clk);
        Start = 1'b1; Op = 2'b11; OperandA = a; OperandB = b;
        @(posedge clk); #1; Start = 1'b0;
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got=%b exp=1", Busy); end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1; n++;
            if (Done) begin gotDone = 1'b1; break; end
            if (Hi !== prevHi || Lo !== prevLo) stable = 1'b0;
        end
        tests++; if (!stable) begin fails++; $display("FAIL b2b_hold got=changed exp=stable"); end
        tests++; if (!gotDone || n != 34) begin fails++; $display("FAIL b2b_latency got=%0d exp=34", n); end
        tests++; if (Hi !== eh || Lo !== el) begin fails++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", Hi, Lo, eh, el); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
        logic        ed;
        int cyc, bc; bit to;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            model(op, a, b, eh, el, ed);
            run_op(op, a, b, cyc, bc, to);
            tests++;
            if (to || cyc != 34 || Hi !== eh || Lo !== el || DivByZero !== ed) begin
                fails++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h_%h dbz=%b cyc=%0d exp=%h_%h dbz=%b cyc=34",
                         i, op, a, b, Hi, Lo, DivByZero, cyc, eh, el, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
